// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock-activity monitor.
// Contents: monitor state encoding and default parameter values.
// Optional build macro used elsewhere: CLK_MON_GLITCH_FILTER_EN.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } mon_state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_MIN_PERIOD = 4;
    localparam int DEF_MAX_PERIOD = 64;
    localparam int DEF_TIMEOUT    = 128;
    localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/clk_mon_edge_det.sv
// Synchronizer and rising-edge detector for the monitored clock.
// Ports:
//   pclock     - sampling clock, rising edge
//   reset      - synchronous active-high reset
//   bclock     - asynchronous monitored clock level
//   edge_pulse - one-cycle pulse per detected rising edge of bclock
//                (named edge_pulse because "edge" is a reserved word)
// Build macro CLK_MON_GLITCH_FILTER_EN: when defined, an edge needs the
// synchronized level to read low, high, high on three consecutive cycles,
// which rejects single-cycle high glitches and adds one cycle of latency.
module clk_mon_edge_det
    import clk_mon_pkg::*;
(
    input  logic pclock,
    input  logic reset,
    input  logic bclock,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic lvl_d;
`ifdef CLK_MON_GLITCH_FILTER_EN
    logic lvl_dd;
`endif

    always_ff @(posedge pclock) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            lvl_d      <= 1'b0;
`ifdef CLK_MON_GLITCH_FILTER_EN
            lvl_dd     <= 1'b0;
`endif
            edge_pulse <= 1'b0;
        end else begin
            sync1 <= bclock;
            sync2 <= sync1;
            lvl_d <= sync2;
`ifdef CLK_MON_GLITCH_FILTER_EN
            lvl_dd     <= lvl_d;
            // oldest sample low, two newest high
            edge_pulse <= sync2 & lvl_d & ~lvl_dd;
`else
            edge_pulse <= sync2 & ~lvl_d;
`endif
        end
    end

endmodule

// File: rtl/clk_monitor.sv
// Clock-activity monitor: measures the period of bclock in pclock cycles
// and reports whether it is present and in range.
// Ports:
//   pclock, reset  - clock and synchronous active-high reset
//   bclock         - monitored buffered clock (asynchronous)
//   enable         - monitor enable; low forces IDLE
//   clk_ok         - high in LOCKED
//   clk_lost       - high in LOST
//   period         - last measured period
//   period_valid   - one-cycle pulse when period updates
//   state          - IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3
// Build macro CLK_MON_GLITCH_FILTER_EN selects the glitch-filtering edge
// detector; measured periods are the same in both builds.
module clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             pclock,
    input  logic             reset,
    input  logic             bclock,
    input  logic             enable,
    output logic             clk_ok,
    output logic             clk_lost,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [1:0]       state
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    mon_state_t        st;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GOOD_W-1:0] good;
    logic              armed;
    logic              edge_pulse;
    logic              measured;
    logic              in_range;
    logic              timeout;

    clk_mon_edge_det u_edge_det (
        .pclock     (pclock),
        .reset      (reset),
        .bclock     (bclock),
        .edge_pulse (edge_pulse)
    );

    // The first edge after entering ACQUIRE only arms; later edges measure.
    assign measured = edge_pulse & armed;
    assign in_range = (cnt >= CNT_W'(MIN_PERIOD)) && (cnt <= CNT_W'(MAX_PERIOD));
    // An edge in the timeout cycle wins and is evaluated as a period instead.
    assign timeout  = !edge_pulse && (cnt == CNT_W'(TIMEOUT));
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge pclock) begin
        if (reset) begin
            st           <= ST_IDLE;
            cnt          <= '0;
            good         <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                st  <= ST_IDLE;
                cnt <= '0;
            end else if (st == ST_IDLE) begin
                st    <= ST_ACQUIRE;
                cnt   <= CNT_W'(1);
                good  <= '0;
                armed <= 1'b0;
            end else begin
                cnt <= (edge_pulse || (st == ST_LOST && timeout)) ? CNT_W'(1) : cnt_inc;
                if (edge_pulse)
                    armed <= 1'b1;
                if (measured) begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                end
                case (st)
                    ST_ACQUIRE: begin
                        if (measured && in_range) begin
                            good <= good + GOOD_W'(1);
                            if (good == GOOD_W'(LOCK_COUNT - 1))
                                st <= ST_LOCKED;
                        end else if (measured || timeout) begin
                            st <= ST_LOST;
                        end
                    end
                    ST_LOCKED: begin
                        if ((measured && !in_range) || timeout)
                            st <= ST_LOST;
                    end
                    ST_LOST: begin
                        // armed stays set, so the recovering period counts as the first good one
                        if (measured && in_range) begin
                            st   <= ST_ACQUIRE;
                            good <= GOOD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state    = st;
    assign clk_ok   = (st == ST_LOCKED);
    assign clk_lost = (st == ST_LOST);

endmodule
